id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised successor to the combinational decode stage.
- Decodes RV32I-subset instructions and adds the opcodes the old decode dropped: JALR, LUI, AUIPC. Flags illegal opcodes.
- Detects load-use hazards and inserts a one-cycle bubble.
- Registers all decode results in an ID/EX pipeline register with valid/ready handshakes on both sides. Sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, datapath and immediate width (32 or 64)
REG_AW, 5, register address width
ALUOP_W, 4, ALU op code width
WB_BYPASS, 1, 1 = forward write-back result into rs data; 0 = read regfile only
CNT_W, 16, width of load-use stall counter (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  branch-redirect kill of this stage
rf_rdata1, rf_rdata2  in  XLEN  regfile read data for rs1/rs2 (combinational read)
wb_regwrite  in  1  write-back enable
wb_rd  in  REG_AW  write-back destination
wb_result  in  XLEN  write-back data
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX consumes ID/EX register
out_pc  out  XLEN  registered PC
out_rs1, out_rs2, out_rd  out  REG_AW  register indices
out_rs1_data, out_rs2_data  out  XLEN  operand data after bypass
out_imm  out  XLEN  sign-extended immediate
out_aluop  out  ALUOP_W  ALU operation
out_alusrc, out_regwrite, out_memread, out_memwrite, out_memtoreg  out  1  control bits
out_branch, out_jal, out_jalr, out_lui, out_auipc  out  1  control-flow / upper-immediate class
out_illegal  out  1  unrecognised opcode (instruction still passed with regwrite=memwrite=0)
stall_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: clk and rst_n is one clock; reset is asynchronous and active-low. While rst_n=0, every registered output is 0, including out_valid, stall_cnt and all control bits.
- in_ready is combinational: (~out_valid | out_ready) & ~load_use.
- load_use is combinational: out_valid & out_memread & out_rd!=0 & in_valid & (out_rd==dec_rs1 | out_rd==dec_rs2). Source use is decoded, not raw: rs2 counts only for R-type, branch and store; rs1 does not count for LUI, AUIPC or JAL.
- Register advance condition: adv = ~out_valid | out_ready.
- Priority on each clock edge:
  - flush: out_valid<=0 and the input is dropped, regardless of adv.
  - else if adv & in_valid & ~load_use: load all decoded fields, out_valid<=1.
  - else if adv: out_valid<=0 (bubble); if load_use, stall_cnt += 1, saturating at all-ones.
  - else: hold all outputs unchanged.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction/cycle except during load-use bubbles.
- Bypass (WB_BYPASS=1): rsN_data = wb_result when wb_regwrite & wb_rd==rsN & rsN!=0, else rf_rdataN. x0 is never bypassed.
- Immediates, sign-extended to XLEN from instr[31]:
  - I-type: ALU-imm, load, JALR.
  - S-type: store.
  - B-type: branch, bit 0 = 0.
  - J-type: JAL, bit 0 = 0.
  - U-type: LUI, AUIPC; instr[31:12]<<12, sign-extended.
  - R-type and illegal: imm = 0.
- Control classes:
  - regwrite=1 for load, ALU, ALU-imm, JAL, JALR, LUI, AUIPC.
  - alusrc=1 for load, store, ALU-imm, JALR, LUI, AUIPC.
  - out_branch=1 for conditional branches only. JAL and JALR have dedicated bits.
- Reset mid-operation: asynchronous clear; the in-flight instruction is lost. A flush coincident with load_use clears the stage; stall_cnt does not increment.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC);
  - the ALU op encodings;
  - a struct/typedef for the decoded control bundle.
- One sub-module, rv_imm_gen: combinational, parametrised by XLEN; instr in, imm out.
- The ALU-op decode stays a function inside the package.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, stall_cnt, out_imm all 0 immediately, without waiting for a clock edge.
- Decode sweep, out_ready=1:
  - addi x1,x0,-1 -> out_imm=0xFFFFFFFF, alusrc=1, regwrite=1.
  - lui x2,0x80000 -> out_imm=0x80000000, out_lui=1.
  - jalr x1,4(x3) -> out_jalr=1, imm=4.
  - opcode 0x7F -> out_illegal=1, regwrite=0.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> in_ready=0 for one cycle, one bubble (out_valid=0), stall_cnt=1, then add issues. The same pair with rd=x0 produces no bubble.
- Bypass: wb_regwrite=1, wb_rd=3, wb_result=0x1234, rf_rdata1=0; decode rs1=3 -> out_rs1_data=0x1234. With rs1=0 and wb_rd=0 -> out_rs1_data=rf_rdata1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; on release the next instruction is loaded with no loss or duplication.
- Flush: flush=1 while in_valid=1 and a load-use is pending -> out_valid=0 next cycle, stall_cnt unchanged.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op encodings, control bundle
// and the small decode helper functions used by the ID stage.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic alusrc;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_LOAD:   begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; end
            OP_STORE:  begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
            OP_BRANCH: c.branch = 1'b1;
            OP_JAL:    begin c.regwrite = 1'b1; c.jal = 1'b1; end
            OP_JALR:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.jalr = 1'b1; end
            OP_OP:     c.regwrite = 1'b1;
            OP_OP_IMM: begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
            OP_LUI:    begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.lui = 1'b1; end
            OP_AUIPC:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.auipc = 1'b1; end
            default:   c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Immediate ALU ops have no SUBI; funct7[5] only selects SRA there.
    function automatic logic [3:0] decode_aluop(input logic [6:0] opcode,
                                                input logic [2:0] funct3,
                                                input logic       funct7_5);
        logic [3:0] op;
        op = ALU_ADD;
        case (opcode)
            OP_OP, OP_OP_IMM: begin
                case (funct3)
                    3'd0:    op = (opcode == OP_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'd1:    op = ALU_SLL;
                    3'd2:    op = ALU_SLT;
                    3'd3:    op = ALU_SLTU;
                    3'd4:    op = ALU_XOR;
                    3'd5:    op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'd6:    op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OP_BRANCH: op = ALU_SUB;
            OP_LUI:    op = ALU_PASSB;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_OP || opcode == OP_BRANCH || opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator; every format is built at 32 bits and
// sign-extended to XLEN from instr[31].
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_LOAD, OP_OP_IMM, OP_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined RV32I decode stage: decodes the IF/ID instruction, bypasses WB data,
// detects load-use hazards and holds results in a handshaked ID/EX register.
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 4,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic               wb_regwrite,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [XLEN-1:0]    wb_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [REG_AW-1:0]  out_rd,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_alusrc,
    output logic               out_regwrite,
    output logic               out_memread,
    output logic               out_memwrite,
    output logic               out_memtoreg,
    output logic               out_branch,
    output logic               out_jal,
    output logic               out_jalr,
    output logic               out_lui,
    output logic               out_auipc,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [6:0]         opcode;
    logic [REG_AW-1:0]  dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0]    dec_imm, dec_rs1_data, dec_rs2_data;
    logic [ALUOP_W-1:0] dec_aluop;
    ctrl_t              dec_ctrl, ctrl_q;
    logic               load_use, adv;

    assign opcode    = in_instr[6:0];
    assign dec_rs1   = REG_AW'(in_instr[19:15]);
    assign dec_rs2   = REG_AW'(in_instr[24:20]);
    assign dec_rd    = REG_AW'(in_instr[11:7]);
    assign dec_ctrl  = decode_ctrl(opcode);
    assign dec_aluop = ALUOP_W'(decode_aluop(opcode, in_instr[14:12], in_instr[30]));

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm)
    );

    generate
        if (WB_BYPASS != 0) begin : g_bypass
            // x0 is hardwired, so a write-back to it must never be forwarded.
            assign dec_rs1_data = (wb_regwrite && wb_rd == dec_rs1 && dec_rs1 != '0) ? wb_result : rf_rdata1;
            assign dec_rs2_data = (wb_regwrite && wb_rd == dec_rs2 && dec_rs2 != '0) ? wb_result : rf_rdata2;
        end else begin : g_no_bypass
            assign dec_rs1_data = rf_rdata1;
            assign dec_rs2_data = rf_rdata2;
        end
    endgenerate

    // Only real source operands count, so LUI/JAL don't stall on garbage rs fields.
    assign load_use = out_valid & ctrl_q.memread & (out_rd != '0) & in_valid &
                      ((uses_rs1(opcode) & (out_rd == dec_rs1)) |
                       (uses_rs2(opcode) & (out_rd == dec_rs2)));
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_aluop    <= '0;
            ctrl_q       <= '0;
            stall_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv && in_valid && !load_use) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1      <= dec_rs1;
            out_rs2      <= dec_rs2;
            out_rd       <= dec_rd;
            out_rs1_data <= dec_rs1_data;
            out_rs2_data <= dec_rs2_data;
            out_imm      <= dec_imm;
            out_aluop    <= dec_aluop;
            ctrl_q       <= dec_ctrl;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (load_use && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_alusrc   = ctrl_q.alusrc;
    assign out_regwrite = ctrl_q.regwrite;
    assign out_memread  = ctrl_q.memread;
    assign out_memwrite = ctrl_q.memwrite;
    assign out_memtoreg = ctrl_q.memtoreg;
    assign out_branch   = ctrl_q.branch;
    assign out_jal      = ctrl_q.jal;
    assign out_jalr     = ctrl_q.jalr;
    assign out_lui      = ctrl_q.lui;
    assign out_auipc    = ctrl_q.auipc;
    assign out_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a spec-level model predicts each issued
// instruction's decode and the handshake/stall behaviour; a monitor checks EX-side transfers.
module tb_id_stage_pipe;
    import rv_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] in_instr = '0, in_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_result = '0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0, out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [3:0]  out_aluop;
    logic        out_alusrc, out_regwrite, out_memread, out_memwrite, out_memtoreg;
    logic        out_branch, out_jal, out_jalr, out_lui, out_auipc, out_illegal;
    logic [15:0] stall_cnt;

    id_stage_pipe #(.XLEN(32), .REG_AW(5), .ALUOP_W(4), .WB_BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_aluop(out_aluop), .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg),
        .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr), .out_lui(out_lui),
        .out_auipc(out_auipc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // ctrl: alusrc regwrite memread memwrite memtoreg branch jal jalr lui auipc illegal
    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluop;
        logic [10:0] ctrl;
        bit          u1, u2;
    } exp_t;

    exp_t sb[$];
    exp_t m_cur, mon_e;
    bit   m_valid = 0, acc = 0;
    int   m_stall = 0;
    int   n_vec = 0, n_err = 0;
    logic [31:0] pc = 32'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input bit is_reg);
        case (f3)
            3'd0: return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] ipc);
        exp_t e;
        e.pc = ipc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.d1 = (wb_regwrite && wb_rd == e.rs1 && e.rs1 != 0) ? wb_result : rf_rdata1;
        e.d2 = (wb_regwrite && wb_rd == e.rs2 && e.rs2 != 0) ? wb_result : rf_rdata2;
        e.imm = 0; e.aluop = ALU_ADD; e.u1 = 1; e.u2 = 0;
        case (ins[6:0])
            7'h03: begin e.ctrl = 11'b111_0100_0000; e.imm = sx(32'(ins[31:20]), 12); end
            7'h23: begin e.ctrl = 11'b100_1000_0000; e.imm = sx(32'({ins[31:25], ins[11:7]}), 12); e.u2 = 1; end
            7'h63: begin e.ctrl = 11'b000_0010_0000; e.aluop = ALU_SUB; e.u2 = 1;
                         e.imm = sx(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13); end
            7'h6F: begin e.ctrl = 11'b010_0001_0000; e.u1 = 0;
                         e.imm = sx(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21); end
            7'h67: begin e.ctrl = 11'b110_0000_1000; e.imm = sx(32'(ins[31:20]), 12); end
            7'h33: begin e.ctrl = 11'b010_0000_0000; e.aluop = alu_of(ins[14:12], ins[30], 1); e.u2 = 1; end
            7'h13: begin e.ctrl = 11'b110_0000_0000; e.aluop = alu_of(ins[14:12], ins[30], 0);
                         e.imm = sx(32'(ins[31:20]), 12); end
            7'h37: begin e.ctrl = 11'b110_0000_0100; e.aluop = ALU_PASSB; e.u1 = 0; e.imm = {ins[31:12], 12'h0}; end
            7'h17: begin e.ctrl = 11'b110_0000_0010; e.u1 = 0; e.imm = {ins[31:12], 12'h0}; end
            default: e.ctrl = 11'b000_0000_0001;
        endcase
        return e;
    endfunction

    // One clock: check handshake/stall state at negedge, advance model, wait past posedge.
    task automatic step();
        exp_t e;
        bit   lu, adv;
        @(negedge clk);
        e   = model(in_instr, in_pc);
        lu  = m_valid && m_cur.ctrl[8] && m_cur.rd != 0 && in_valid &&
              ((e.u1 && m_cur.rd == e.rs1) || (e.u2 && m_cur.rd == e.rs2));
        adv = !m_valid || out_ready;
        chk("in_ready", in_ready, adv && !lu);
        chk("out_valid", out_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_valid && !out_ready) chk("hold_pc", out_pc, m_cur.pc);
        acc = 0;
        if (flush) m_valid = 0;
        else if (adv && in_valid && !lu) begin sb.push_back(e); m_cur = e; m_valid = 1; acc = 1; end
        else if (adv) begin
            m_valid = 0;
            if (lu && m_stall != 16'hFFFF) m_stall++;
        end
        @(posedge clk); #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins);
        in_valid = v; in_instr = ins; in_pc = pc;
        step();
        if (acc) pc += 4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 11);
        case (k)
            0, 1, 2: r[6:0] = 7'h03;
            3:  r[6:0] = 7'h23;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h6F;
            6:  r[6:0] = 7'h67;
            7:  r[6:0] = 7'h33;
            8:  r[6:0] = 7'h13;
            9:  r[6:0] = 7'h37;
            10: r[6:0] = 7'h17;
            default: r[6:0] = r[31] ? 7'h7F : 7'h0B;
        endcase
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && (out_ready || flush)) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_empty actual=out_valid expected=no_output @%0t", $time);
            end else begin
                mon_e = sb.pop_front();
                if (out_ready) begin
                    chk("pc", out_pc, mon_e.pc);
                    chk("rs1", out_rs1, mon_e.rs1);
                    chk("rs2", out_rs2, mon_e.rs2);
                    chk("rd", out_rd, mon_e.rd);
                    chk("rs1_data", out_rs1_data, mon_e.d1);
                    chk("rs2_data", out_rs2_data, mon_e.d2);
                    chk("imm", out_imm, mon_e.imm);
                    chk("aluop", out_aluop, mon_e.aluop);
                    chk("ctrl", {out_alusrc, out_regwrite, out_memread, out_memwrite, out_memtoreg,
                                 out_branch, out_jal, out_jalr, out_lui, out_auipc, out_illegal}, mon_e.ctrl);
                end
            end
        end
    end

    initial begin
        logic [31:0] cur;
        bit have;
        have = 0; cur = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_ctrl", {out_regwrite, out_memread, out_illegal}, 0);
        rst_n = 1'b1;
        rf_rdata1 = 32'hAAAA_0001; rf_rdata2 = 32'hBBBB_0002;

        // Decode sweep
        cyc(1, 32'hFFF0_0093);   // addi x1,x0,-1
        cyc(1, 32'h8000_0137);   // lui x2,0x80000
        cyc(1, 32'h0041_80E7);   // jalr x1,4(x3)
        cyc(1, 32'h0000_007F);   // illegal
        // Load-use and the x0 variant
        cyc(1, 32'h0000_A283);   // lw x5,0(x1)
        cyc(1, 32'h0022_8333);   // add x6,x5,x2 -> bubble
        cyc(1, 32'h0022_8333);
        chk("lu_count", stall_cnt, 1);
        cyc(1, 32'h0000_A003);   // lw x0,0(x1)
        cyc(1, 32'h0020_0333);   // add x6,x0,x2
        chk("x0_no_stall", stall_cnt, 1);
        // Bypass
        wb_regwrite = 1; wb_rd = 3; wb_result = 32'h1234; rf_rdata1 = 0;
        cyc(1, 32'h0001_8213);   // addi x4,x3,0
        wb_rd = 0; rf_rdata1 = 32'h55;
        cyc(1, 32'h0000_0213);   // addi x4,x0,0
        wb_regwrite = 0;
        // Backpressure
        cyc(1, 32'hFFF0_0093);
        out_ready = 0;
        repeat (3) cyc(1, 32'h8000_0137);
        out_ready = 1;
        cyc(1, 32'h8000_0137);
        cyc(0, 32'h0);
        // Flush over a pending load-use
        cyc(1, 32'h0000_A283);
        flush = 1;
        cyc(1, 32'h0022_8333);
        flush = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_stall", stall_cnt, 1);
        // Asynchronous reset mid-stream
        cyc(1, 32'hFFF0_0093);
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_stall", stall_cnt, 0);
        chk("async_imm", out_imm, 0);
        sb.delete(); m_valid = 0; m_stall = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic; an unaccepted instruction is held until taken or flushed
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 4) != 0) begin cur = rand_instr(); have = 1; end
            in_valid    = have;
            in_instr    = have ? cur : $urandom();
            in_pc       = pc;
            out_ready   = $urandom_range(0, 3) != 0;
            flush       = $urandom_range(0, 15) == 0;
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 3));
            wb_result   = $urandom();
            rf_rdata1   = $urandom();
            rf_rdata2   = $urandom();
            step();
            if (acc || flush) begin have = 0; pc += 4; end
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
